time_date_counter: RTL and testbench

- Real-time clock/calendar core that sits directly downstream of the key controller.
- Consumes the key controller's edited time, date and alarm values, its SETTING request and its MODE word; returns SETTING_OK plus the running TIME, DATE and ALARM_TIME that feed back into the key controller and the display.
- Generates the 1 Hz tick internally, counts sec/min/hour/day/month/year with month-length and leap-year rules, and flags the alarm match.

---
 rtl/time_date_counter.sv | 168 ++++++++++++++++
 tb/tb_time_date_counter.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/time_date_counter.sv
// Real-time clock/calendar: internal 1 Hz prescaler, sec..year cascade with
// month-length and leap-year rules, SETTING/SETTING_OK load handshake and alarm match.
module time_date_counter #(
  parameter int TICK_CNT = 1000
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [5:0]  MODE,
  input  logic        SETTING,
  input  logic [17:0] SET_TIME,
  input  logic [15:0] SET_DATE,
  input  logic [16:0] SET_ALARM_TIME,
  input  logic        ALARM_ENABLE,
  output logic        SETTING_OK,
  output logic [17:0] TIME,
  output logic [15:0] DATE,
  output logic [16:0] ALARM_TIME,
  output logic        ALARM_HIT
);

  localparam logic [19:0] TICK_MAX = 20'(TICK_CNT - 1);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_ACK = 2'd1, S_WAIT_LOW = 2'd2} state_t;

  state_t      state_q;
  logic [19:0] presc_q, presc_d;
  logic [5:0]  sec_q, sec_d, min_q, min_d;
  logic [4:0]  hour_q, hour_d, day_q, day_d;
  logic [3:0]  month_q, month_d;
  logic [6:0]  year_q, year_d;
  logic        mer_q;
  logic [16:0] alarm_q, alarm_d;
  logic        ok_q, hit_q, hit_d;

  logic        hold_s, tick_s, ld_time_s, ld_alarm_s;
  logic [4:0]  ld_hour_s, ld_day_s, ld_mlen_s;
  logic [5:0]  ld_min_s, ld_sec_s;
  logic [3:0]  ld_month_s;
  logic [6:0]  ld_year_s;

  function automatic logic [4:0] month_len(input logic [3:0] month, input logic [6:0] year);
    case (month)
      4'd2:                     month_len = (year[1:0] == 2'd0) ? 5'd29 : 5'd28;
      4'd4, 4'd6, 4'd9, 4'd11:  month_len = 5'd30;
      default:                  month_len = 5'd31;
    endcase
  endfunction

  // Load sanitising and tick cascade; a time load wins over a same-cycle tick
  always_comb begin
    hold_s     = ~MODE[5] & MODE[4] & MODE[0];
    tick_s     = ~hold_s & (presc_q == TICK_MAX);
    ld_time_s  = (state_q == S_IDLE) & SETTING & ~MODE[5];
    ld_alarm_s = (state_q == S_IDLE) & SETTING & MODE[5];

    ld_hour_s  = (SET_TIME[16:12] > 5'd23) ? 5'd0 : SET_TIME[16:12];
    ld_min_s   = (SET_TIME[11:6] > 6'd59) ? 6'd0 : SET_TIME[11:6];
    ld_sec_s   = (SET_TIME[5:0] > 6'd59) ? 6'd0 : SET_TIME[5:0];
    ld_year_s  = (SET_DATE[15:9] > 7'd99) ? 7'd0 : SET_DATE[15:9];
    ld_month_s = ((SET_DATE[8:5] == 4'd0) || (SET_DATE[8:5] > 4'd12)) ? 4'd1 : SET_DATE[8:5];
    ld_mlen_s  = month_len(ld_month_s, ld_year_s);
    if (SET_DATE[4:0] == 5'd0) begin
      ld_day_s = 5'd1;
    end else if (SET_DATE[4:0] > ld_mlen_s) begin
      ld_day_s = ld_mlen_s;
    end else begin
      ld_day_s = SET_DATE[4:0];
    end

    presc_d = presc_q;
    sec_d   = sec_q;
    min_d   = min_q;
    hour_d  = hour_q;
    day_d   = day_q;
    month_d = month_q;
    year_d  = year_q;

    if (ld_time_s) begin
      presc_d = 20'd0;
      sec_d   = ld_sec_s;
      min_d   = ld_min_s;
      hour_d  = ld_hour_s;
      day_d   = ld_day_s;
      month_d = ld_month_s;
      year_d  = ld_year_s;
    end else if (hold_s) begin
      presc_d = presc_q;
    end else begin
      presc_d = tick_s ? 20'd0 : presc_q + 20'd1;
      if (tick_s) begin
        if (sec_q == 6'd59) begin
          sec_d = 6'd0;
          if (min_q == 6'd59) begin
            min_d = 6'd0;
            if (hour_q == 5'd23) begin
              hour_d = 5'd0;
              if (day_q == month_len(month_q, year_q)) begin
                day_d = 5'd1;
                if (month_q == 4'd12) begin
                  month_d = 4'd1;
                  year_d  = (year_q == 7'd99) ? 7'd0 : year_q + 7'd1;
                end else begin
                  month_d = month_q + 4'd1;
                end
              end else begin
                day_d = day_q + 5'd1;
              end
            end else begin
              hour_d = hour_q + 5'd1;
            end
          end else begin
            min_d = min_q + 6'd1;
          end
        end else begin
          sec_d = sec_q + 6'd1;
        end
      end else begin
        sec_d = sec_q;
      end
    end

    alarm_d = ld_alarm_s ? SET_ALARM_TIME : alarm_q;
    hit_d   = tick_s & ~ld_time_s & ALARM_ENABLE & ({hour_d, min_d, sec_d} == alarm_d);
  end

  // State registers and the load handshake FSM
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= S_IDLE;
      presc_q <= 20'd0;
      sec_q   <= 6'd0;
      min_q   <= 6'd0;
      hour_q  <= 5'd0;
      day_q   <= 5'd1;
      month_q <= 4'd1;
      year_q  <= 7'd0;
      mer_q   <= 1'b0;
      alarm_q <= 17'd0;
      ok_q    <= 1'b0;
      hit_q   <= 1'b0;
    end else begin
      presc_q <= presc_d;
      sec_q   <= sec_d;
      min_q   <= min_d;
      hour_q  <= hour_d;
      day_q   <= day_d;
      month_q <= month_d;
      year_q  <= year_d;
      mer_q   <= SET_TIME[17];
      alarm_q <= alarm_d;
      hit_q   <= hit_d;
      ok_q    <= (state_q == S_ACK);
      case (state_q)
        S_IDLE:     state_q <= SETTING ? S_ACK : S_IDLE;
        S_ACK:      state_q <= S_WAIT_LOW;
        S_WAIT_LOW: state_q <= SETTING ? S_WAIT_LOW : S_IDLE;
        default:    state_q <= S_IDLE;
      endcase
    end
  end

  assign SETTING_OK = ok_q;
  assign TIME       = {mer_q, hour_q, min_q, sec_q};
  assign DATE       = {year_q, month_q, day_q};
  assign ALARM_TIME = alarm_q;
  assign ALARM_HIT  = hit_q;

endmodule

// File: tb/tb_time_date_counter.sv
// Directed bench for time_date_counter: expectations queued as stimulus is
// driven, popped and checked with immediate assertions when outputs are sampled.
module tb_time_date_counter;
  localparam int TICK = 10;

  logic        CLK, RESET, SETTING, ALARM_ENABLE;
  logic [5:0]  MODE;
  logic [17:0] SET_TIME;
  logic [15:0] SET_DATE;
  logic [16:0] SET_ALARM_TIME;
  logic        SETTING_OK, ALARM_HIT;
  logic [17:0] TIME;
  logic [15:0] DATE;
  logic [16:0] ALARM_TIME;

  logic [31:0] exp_q[$];
  int n_assert = 0;
  int n_fail   = 0;
  int ok_cnt;

  time_date_counter #(.TICK_CNT(TICK)) dut (
    .CLK(CLK), .RESET(RESET), .MODE(MODE), .SETTING(SETTING),
    .SET_TIME(SET_TIME), .SET_DATE(SET_DATE), .SET_ALARM_TIME(SET_ALARM_TIME),
    .ALARM_ENABLE(ALARM_ENABLE), .SETTING_OK(SETTING_OK), .TIME(TIME),
    .DATE(DATE), .ALARM_TIME(ALARM_TIME), .ALARM_HIT(ALARM_HIT)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  function automatic logic [17:0] tm(input int h, input int m, input int s);
    return {1'b0, 5'(h), 6'(m), 6'(s)};
  endfunction

  function automatic logic [15:0] dt(input int y, input int mo, input int d);
    return {7'(y), 4'(mo), 5'(d)};
  endfunction

  task automatic step(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic expect_v(input logic [31:0] v);
    exp_q.push_back(v);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs);
    logic [31:0] exp;
    exp = 32'hDEAD_BEEF;
    if (exp_q.size() > 0) exp = exp_q.pop_front();
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic load(input logic [5:0] mode, input logic [17:0] t,
                      input logic [15:0] d, input logic [16:0] a);
    MODE = mode; SET_TIME = t; SET_DATE = d; SET_ALARM_TIME = a;
    SETTING = 1'b1;
    step(1);
    SETTING = 1'b0;
    step(2);
  endtask

  initial begin
    RESET = 1'b1; SETTING = 1'b0; ALARM_ENABLE = 1'b0; MODE = 6'b000000;
    SET_TIME = 18'd0; SET_DATE = 16'd0; SET_ALARM_TIME = 17'd0;
    step(2);
    expect_v(32'(tm(0, 0, 0)));  chk("reset_time", 32'(TIME));
    expect_v(32'(dt(0, 1, 1)));  chk("reset_date", 32'(DATE));
    expect_v(32'd0);             chk("reset_alarm", 32'(ALARM_TIME));
    expect_v(32'd0);             chk("reset_ok", 32'(SETTING_OK));
    expect_v(32'd0);             chk("reset_hit", 32'(ALARM_HIT));

    // three seconds of free running
    RESET = 1'b0;
    ok_cnt = 0;
    for (int i = 0; i < 3 * TICK; i++) begin
      step(1);
      ok_cnt += int'(SETTING_OK);
    end
    expect_v(32'(tm(0, 0, 3)));  chk("run3_time", 32'(TIME));
    expect_v(32'(dt(0, 1, 1)));  chk("run3_date", 32'(DATE));
    expect_v(32'd0);             chk("run3_no_ok", 32'(ok_cnt));

    // load with SETTING held high, year rollover on next tick
    MODE = 6'b010011; SET_TIME = tm(23, 59, 59); SET_DATE = dt(23, 12, 31);
    SETTING = 1'b1;
    step(1);
    expect_v(32'(tm(23, 59, 59))); chk("load_time", 32'(TIME));
    expect_v(32'(dt(23, 12, 31))); chk("load_date", 32'(DATE));
    SET_TIME = tm(1, 2, 3); SET_DATE = dt(5, 5, 5);
    ok_cnt = 0;
    for (int i = 0; i < 6; i++) begin
      step(1);
      ok_cnt += int'(SETTING_OK);
    end
    expect_v(32'd1);               chk("ok_one_cycle", 32'(ok_cnt));
    expect_v(32'(tm(23, 59, 59))); chk("no_reload", 32'(TIME));
    SETTING = 1'b0;
    step(1);
    MODE = 6'b000000;
    step(TICK);
    expect_v(32'(tm(0, 0, 0)));    chk("roll_time", 32'(TIME));
    expect_v(32'(dt(24, 1, 1)));   chk("roll_date", 32'(DATE));

    // leap and non-leap February
    load(6'b010011, tm(23, 59, 59), dt(24, 2, 28), 17'd0);
    MODE = 6'b000000;
    step(TICK);
    expect_v(32'(dt(24, 2, 29)));  chk("leap_date", 32'(DATE));
    load(6'b010011, tm(23, 59, 59), dt(23, 2, 28), 17'd0);
    MODE = 6'b000000;
    step(TICK);
    expect_v(32'(dt(23, 3, 1)));   chk("nonleap_date", 32'(DATE));
    expect_v(32'(tm(0, 0, 0)));    chk("nonleap_time", 32'(TIME));

    // sanitising
    load(6'b010011, tm(25, 60, 10), dt(23, 4, 31), 17'd0);
    expect_v(32'(tm(0, 0, 10)));   chk("san_time", 32'(TIME));
    expect_v(32'(dt(23, 4, 30)));  chk("san_date", 32'(DATE));
    load(6'b010011, tm(0, 0, 10), dt(23, 0, 15), 17'd0);
    expect_v(32'(dt(23, 1, 15)));  chk("san_month0", 32'(DATE));

    // alarm load leaves time alone
    load(6'b110011, tm(9, 9, 9), dt(9, 9, 9), 17'(tm(7, 0, 0)));
    expect_v(32'(tm(7, 0, 0)));    chk("alarm_load", 32'(ALARM_TIME));
    expect_v(32'(tm(0, 0, 10)));   chk("alarm_time_kept", 32'(TIME));
    expect_v(32'(dt(23, 1, 15)));  chk("alarm_date_kept", 32'(DATE));

    // alarm match with enable
    ALARM_ENABLE = 1'b1;
    load(6'b010011, tm(6, 59, 59), dt(23, 1, 15), 17'd0);
    MODE = 6'b000000;
    step(TICK - 1);
    expect_v(32'd0);               chk("hit_early", 32'(ALARM_HIT));
    step(1);
    expect_v(32'd1);               chk("hit_pulse", 32'(ALARM_HIT));
    expect_v(32'(tm(7, 0, 0)));    chk("hit_time", 32'(TIME));
    step(1);
    expect_v(32'd0);               chk("hit_one_cycle", 32'(ALARM_HIT));

    // alarm match with enable low
    ALARM_ENABLE = 1'b0;
    load(6'b010011, tm(6, 59, 59), dt(23, 1, 15), 17'd0);
    MODE = 6'b000000;
    step(TICK);
    expect_v(32'd0);               chk("hit_disabled", 32'(ALARM_HIT));
    expect_v(32'(tm(7, 0, 0)));    chk("nohit_time", 32'(TIME));

    // hold freezes counting; meridian still tracks input
    MODE = 6'b010101; SET_TIME = 18'h20000;
    step(2 * TICK);
    expect_v(32'(tm(7, 0, 0) | 18'h20000)); chk("hold_time", 32'(TIME));

    // reset while waiting for SETTING to drop
    MODE = 6'b010011; SET_TIME = tm(12, 34, 56) | 18'h20000; SET_DATE = dt(50, 6, 15);
    SETTING = 1'b1;
    step(2);
    RESET = 1'b1; SETTING = 1'b0;
    step(1);
    expect_v(32'(tm(0, 0, 0)));    chk("rst_wl_time", 32'(TIME));
    expect_v(32'(dt(0, 1, 1)));    chk("rst_wl_date", 32'(DATE));
    expect_v(32'd0);               chk("rst_wl_alarm", 32'(ALARM_TIME));
    expect_v(32'd0);               chk("rst_wl_ok", 32'(SETTING_OK));
    RESET = 1'b0; SET_TIME = tm(1, 1, 1); SET_DATE = dt(10, 10, 10);
    SETTING = 1'b1;
    step(1);
    expect_v(32'(tm(1, 1, 1)));    chk("post_rst_time", 32'(TIME));
    expect_v(32'(dt(10, 10, 10))); chk("post_rst_date", 32'(DATE));
    step(1);
    expect_v(32'd1);               chk("post_rst_ok", 32'(SETTING_OK));
    SETTING = 1'b0;
    step(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
